// File: rtl/vga_timing_out.sv
// VGA raster timing generator: pixel coordinate counters, sync pulses and a
// registered RGB output stage that blanks to black outside the visible area.
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] paint_r,
    input  logic [3:0] paint_g,
    input  logic [3:0] paint_b,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       de,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters are 10 bits; a raster that does not fit is a build error.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_out: H_TOTAL/V_TOTAL must not exceed 1024");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_count
            $error("vga_timing_out: every timing count must be at least 1");
        end
    endgenerate

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic hs_raw;
    logic vs_raw;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == H_LAST) begin
            sx <= '0;
            sy <= (sy == V_LAST) ? 10'd0 : sy + 10'd1;
        end else begin
            sx <= sx + 10'd1;
        end
    end

    assign de          = (sx < H_VIS) && (sy < V_VIS);
    assign frame_start = (sx == 10'd0) && (sy == V_VIS);
    assign hs_raw      = (sx >= HS_FIRST) && (sx <= HS_LAST);
    assign vs_raw      = (sy >= VS_FIRST) && (sy <= VS_LAST);

    // Pin stage: one register so all pins lag sx/sy by exactly one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vga_vs <= vs_raw ? SYNC_POL : ~SYNC_POL;
            vga_r  <= de ? paint_r : 4'd0;
            vga_g  <= de ? paint_g : 4'd0;
            vga_b  <= de ? paint_b : 4'd0;
        end
    end

endmodule
